sysid_check_ctrl: RTL and testbench
===================================

SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0000, meaning the system ID value the check requires.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'h0000_0000, meaning the build timestamp value the check requires.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..65535, meaning the maximum consecutive waitrequest cycles tolerated per read.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, level-sampled request to run one check sequence.
REQ-007 SHALL have port avm_address, output, 1, sysid slave word address (0 = ID, 1 = timestamp).
REQ-008 SHALL have port avm_read, output, 1, Avalon-MM read strobe to the sysid slave.
REQ-009 SHALL have port avm_readdata, input, 32, read data from the sysid slave.
REQ-010 SHALL have port avm_waitrequest, input, 1, slave stall; tie 0 for a zero-wait slave.
REQ-011 SHALL have port busy, output, 1, high from sequence start until done.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at sequence end.
REQ-013 SHALL have port pass, output, 1, sticky result: both values matched, no timeout.
REQ-014 SHALL have ports id_mismatch, ts_mismatch, timeout, outputs, 1 each, sticky failure flags.
REQ-015 SHALL have ports id_value, ts_value, outputs, 32 each, last captured slave data.

Function
REQ-016 SHALL implement states IDLE, RD_ID, RD_TS, CMP, DONE.
REQ-017 IDLE or DONE with start=1 SHALL clear pass/flags/values and enter RD_ID next cycle; start SHALL be ignored in RD_ID, RD_TS and CMP.
REQ-018 RD_ID SHALL drive avm_read=1, avm_address=0, holding both stable while avm_waitrequest=1.
REQ-019 A read SHALL complete on the first cycle with avm_read=1 and avm_waitrequest=0; avm_readdata is captured into id_value/ts_value on that edge.
REQ-020 RD_ID completion SHALL go to RD_TS (avm_address=1, same rules); RD_TS completion SHALL go to CMP.
REQ-021 CMP SHALL set id_mismatch=(id_value!=EXPECTED_ID), ts_mismatch=(ts_value!=EXPECTED_TS), pass=both equal, then enter DONE.
REQ-022 Entry into DONE SHALL produce done=1 for exactly one cycle; busy=0 in IDLE and DONE only.
REQ-023 With zero wait states: start sampled at edge 0 -> RD_ID cycle 1, RD_TS cycle 2, CMP cycle 3, done=1 and results valid in cycle 4.
REQ-024 A per-read wait counter SHALL reset on each read start and count cycles with avm_waitrequest=1; reaching TIMEOUT_CYCLES SHALL drop avm_read, set timeout=1, pass=0, skip CMP, and enter DONE.
REQ-025 avm_read SHALL be 0 in IDLE, CMP and DONE; no read SHALL ever be abandoned except via timeout.
REQ-026 start held high in DONE SHALL restart a sequence every time DONE is reached (back-to-back checks).

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE, avm_read=0, avm_address=0, busy=0, done=0, pass=0, all flags 0, id_value=ts_value=0, wait counter 0.
REQ-028 Reset asserted mid-read SHALL drop avm_read immediately; the sequence is not resumed after release.

Configuration
REQ-029 Macro SYSID_CHECK_TS_EN defined SHALL include RD_TS and the timestamp compare as above.
REQ-030 Macro SYSID_CHECK_TS_EN undefined SHALL make RD_ID completion go directly to CMP, hold ts_value=0, tie ts_mismatch=0, and base pass on ID match only (zero-wait done in cycle 3).

Structure
REQ-031 Package sysid_check_pkg SHALL hold the state enum type and constants SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1.
REQ-032 The wait/timeout counter SHALL be sub-module sysid_check_timer (inputs clear, enable; output expired; parameter TIMEOUT_CYCLES).

Verification
REQ-033 Zero-wait slave returning EXPECTED_ID then EXPECTED_TS, start pulse -> done in cycle 4, pass=1, all flags 0.
REQ-034 Slave returns ID 32'hDEAD_BEEF with EXPECTED_ID=0 -> id_mismatch=1, pass=0, id_value=32'hDEAD_BEEF.
REQ-035 Waitrequest held 3 cycles on each read, TIMEOUT_CYCLES=255 -> address/read stable while stalled, done in cycle 10, pass=1.
REQ-036 Waitrequest stuck high, TIMEOUT_CYCLES=4 -> avm_read drops after 4 stall cycles, timeout=1, pass=0, done pulse once.
REQ-037 reset_n pulled low during RD_TS -> avm_read=0 same cycle, all outputs 0, IDLE after release until next start.
REQ-038 Build without SYSID_CHECK_TS_EN, matching ID -> avm_address never 1, done in cycle 3, pass=1, ts_value=0.

Source files
------------

// File: rtl/sysid_check_pkg.sv
//----------------------------------------------------------------------------
// Module      : sysid_check_pkg
// Description : Shared types and constants for the sysid check controller.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package sysid_check_pkg;

    // Controller sequence states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        RD_TS = 3'd2,
        CMP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Word addresses inside the sysid slave
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sysid_check_timer.sv
//----------------------------------------------------------------------------
// Module      : sysid_check_timer
// Description : Per-read stall counter; flags the stall cycle on which the
//               TIMEOUT_CYCLES-th consecutive waitrequest is seen.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module sysid_check_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] c_limit = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_count;

    // Count stalled cycles; restart whenever the read is not stalled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Expired during the stall cycle that makes the count reach the limit
    assign expired = enable && (r_count == c_limit);

endmodule

`default_nettype wire

// File: rtl/sysid_check_ctrl.sv
//----------------------------------------------------------------------------
// Module      : sysid_check_ctrl
// Description : Reads the system ID (and optionally the build timestamp)
//               from an Avalon-MM sysid slave and compares them against
//               expected values. Read stalls are bounded by a timeout.
//               Optional feature macro: SYSID_CHECK_TS_EN (timestamp read
//               and compare; when undefined only the ID is checked).
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module sysid_check_ctrl
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_in_read;
    logic        w_stall;
    logic        w_rd_complete;
    logic        w_expired;
    logic        w_launch;
    logic        w_ts_ok;
    logic        r_done;
    logic        r_pass;
    logic        r_id_mismatch;
    logic        r_ts_mismatch;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    assign w_in_read     = (r_state == RD_ID) || (r_state == RD_TS);
    assign w_stall       = w_in_read && avm_waitrequest;
    assign w_rd_complete = w_in_read && !avm_waitrequest;
    assign w_launch      = ((r_state == IDLE) || (r_state == DONE)) && start;

`ifdef SYSID_CHECK_TS_EN
    assign w_ts_ok = (r_ts_value == EXPECTED_TS);
`else
    assign w_ts_ok = 1'b1;
`endif

    sysid_check_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!w_stall),
        .enable  (w_stall),
        .expired (w_expired)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and bus strobes; read/address are pure functions of state
    // so an asynchronous reset drops the read in the same cycle
    always_comb begin
        w_next_state = r_state;
        avm_read     = 1'b0;
        avm_address  = SYSID_ADDR_ID;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next_state = RD_ID;
            end
            RD_ID: begin
                avm_read    = 1'b1;
                avm_address = SYSID_ADDR_ID;
                if (w_rd_complete) begin
`ifdef SYSID_CHECK_TS_EN
                    w_next_state = RD_TS;
`else
                    w_next_state = CMP;
`endif
                end else if (w_expired) begin
                    w_next_state = DONE;
                end
            end
            RD_TS: begin
                avm_read    = 1'b1;
                avm_address = SYSID_ADDR_TS;
                if (w_rd_complete) begin
                    w_next_state = CMP;
                end else if (w_expired) begin
                    w_next_state = DONE;
                end
            end
            CMP: begin
                w_next_state = DONE;
            end
            DONE: begin
                busy = 1'b0;
                if (start) w_next_state = RD_ID;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = IDLE;
            end
        endcase
    end

    // Capture read data, evaluate results and produce the done pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_id_mismatch <= 1'b0;
            r_ts_mismatch <= 1'b0;
            r_timeout     <= 1'b0;
            r_id_value    <= '0;
            r_ts_value    <= '0;
        end else begin
            r_done <= (w_next_state == DONE) && (r_state != DONE);
            if (w_launch) begin
                r_pass        <= 1'b0;
                r_id_mismatch <= 1'b0;
                r_ts_mismatch <= 1'b0;
                r_timeout     <= 1'b0;
                r_id_value    <= '0;
                r_ts_value    <= '0;
            end else begin
                if ((r_state == RD_ID) && w_rd_complete) begin
                    r_id_value <= avm_readdata;
                end
`ifdef SYSID_CHECK_TS_EN
                if ((r_state == RD_TS) && w_rd_complete) begin
                    r_ts_value <= avm_readdata;
                end
`endif
                if (w_stall && w_expired) begin
                    r_timeout <= 1'b1;
                    r_pass    <= 1'b0;
                end
                if (r_state == CMP) begin
                    r_id_mismatch <= (r_id_value != EXPECTED_ID);
                    r_ts_mismatch <= !w_ts_ok;
                    r_pass        <= (r_id_value == EXPECTED_ID) && w_ts_ok;
                end
            end
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign id_mismatch = r_id_mismatch;
    assign ts_mismatch = r_ts_mismatch;
    assign timeout     = r_timeout;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule

`default_nettype wire

// File: tb/tb_sysid_check_ctrl.sv
//----------------------------------------------------------------------------
// Module      : tb_sysid_check_ctrl
// Description : Self-checking bench for sysid_check_ctrl. Two instances:
//               A (non-zero expected values, TIMEOUT_CYCLES=255) and
//               B (default expected values, TIMEOUT_CYCLES=4), each with a
//               behavioural sysid slave inserting a programmable stall.
//               Honours SYSID_CHECK_TS_EN the same way as the design.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_sysid_check_ctrl;

`ifdef SYSID_CHECK_TS_EN
    localparam bit TS = 1'b1;
`else
    localparam bit TS = 1'b0;
`endif

    logic clk;
    logic reset_n;

    // Instance A
    logic        start_a, addr_a, read_a, wr_a, busy_a, done_a, pass_a;
    logic        idmm_a, tsmm_a, to_a;
    logic [31:0] rdata_a, idv_a, tsv_a, id_a, ts_a;
    int          stall_a, scnt_a;
    // Instance B
    logic        start_b, addr_b, read_b, wr_b, busy_b, done_b, pass_b;
    logic        idmm_b, tsmm_b, to_b;
    logic [31:0] rdata_b, idv_b, tsv_b, id_b, ts_b;
    int          stall_b, scnt_b;

    logic sel_b;
    logic        m_addr, m_read, m_wr, m_busy, m_done, m_pass, m_idmm, m_tsmm, m_to;
    logic [31:0] m_idv, m_tsv;

    int checks = 0;
    int errors = 0;

    sysid_check_ctrl #(
        .EXPECTED_ID    (32'h1234_5678),
        .EXPECTED_TS    (32'hCAFE_F00D),
        .TIMEOUT_CYCLES (255)
    ) dut_a (
        .clock (clk), .reset_n (reset_n), .start (start_a),
        .avm_address (addr_a), .avm_read (read_a), .avm_readdata (rdata_a),
        .avm_waitrequest (wr_a), .busy (busy_a), .done (done_a), .pass (pass_a),
        .id_mismatch (idmm_a), .ts_mismatch (tsmm_a), .timeout (to_a),
        .id_value (idv_a), .ts_value (tsv_a)
    );

    sysid_check_ctrl #(
        .TIMEOUT_CYCLES (4)
    ) dut_b (
        .clock (clk), .reset_n (reset_n), .start (start_b),
        .avm_address (addr_b), .avm_read (read_b), .avm_readdata (rdata_b),
        .avm_waitrequest (wr_b), .busy (busy_b), .done (done_b), .pass (pass_b),
        .id_mismatch (idmm_b), .ts_mismatch (tsmm_b), .timeout (to_b),
        .id_value (idv_b), .ts_value (tsv_b)
    );

    // Behavioural slaves: stall each read for stall_x cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scnt_a <= 0;
            scnt_b <= 0;
        end else begin
            scnt_a <= (read_a && wr_a) ? scnt_a + 1 : 0;
            scnt_b <= (read_b && wr_b) ? scnt_b + 1 : 0;
        end
    end
    assign wr_a    = read_a && (scnt_a < stall_a);
    assign wr_b    = read_b && (scnt_b < stall_b);
    assign rdata_a = addr_a ? ts_a : id_a;
    assign rdata_b = addr_b ? ts_b : id_b;

    // Selected-instance view
    assign m_addr = sel_b ? addr_b : addr_a;
    assign m_read = sel_b ? read_b : read_a;
    assign m_wr   = sel_b ? wr_b   : wr_a;
    assign m_busy = sel_b ? busy_b : busy_a;
    assign m_done = sel_b ? done_b : done_a;
    assign m_pass = sel_b ? pass_b : pass_a;
    assign m_idmm = sel_b ? idmm_b : idmm_a;
    assign m_tsmm = sel_b ? tsmm_b : tsmm_a;
    assign m_to   = sel_b ? to_b   : to_a;
    assign m_idv  = sel_b ? idv_b  : idv_a;
    assign m_tsv  = sel_b ? tsv_b  : tsv_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        b;
        logic [31:0] id;
        logic [31:0] ts;
        int          stalls;
        logic        hold;
        int          exp_dc;
        int          exp_rd;
        logic        exp_pass;
        logic        exp_idmm;
        logic        exp_tsmm;
        logic        exp_to;
        logic [31:0] exp_idv;
        logic [31:0] exp_tsv;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One start pulse; returns the cycle of the done pulse and the number
    // of cycles with avm_read high. Cycle 1 follows the edge sampling start.
    task automatic run_seq(input logic b, input logic hold, output int dc, output int rd);
        logic prev_stall;
        logic prev_addr;
        sel_b = b;
        dc = -1;
        rd = 0;
        prev_stall = 1'b0;
        prev_addr  = 1'b0;
        @(negedge clk);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int cyc = 1; cyc <= 40 && dc < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk("busy_c1", {31'd0, m_busy}, 32'd1);
                chk("cleared_c1", {28'd0, m_pass, m_idmm, m_tsmm, m_to}, 32'd0);
            end
            if (hold && prev_stall) begin
                chk("stall_hold_read", {31'd0, m_read}, 32'd1);
                chk("stall_hold_addr", {31'd0, m_addr}, {31'd0, prev_addr});
            end
            if (!TS && m_read) chk("addr_ts_unused", {31'd0, m_addr}, 32'd0);
            if (m_read) rd++;
            prev_stall = m_read && m_wr;
            prev_addr  = m_addr;
            if (m_done) dc = cyc;
        end
        if (dc < 0) begin
            checks++;
            errors++;
            $display("FAIL done_wait: no done within 40 cycles");
        end
        @(negedge clk);
        chk("done_width", {31'd0, m_done}, 32'd0);
        chk("idle_busy", {31'd0, m_busy}, 32'd0);
    endtask

    initial begin
        int dc, rd, n;
        bit found;

        vecs[0] = '{1'b0, 32'h1234_5678, 32'hCAFE_F00D, 0, 1'b1, TS ? 4 : 3, TS ? 2 : 1,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, TS ? 32'hCAFE_F00D : 32'h0};
        vecs[1] = '{1'b0, 32'h1234_5678, 32'h0000_0001, 0, 1'b1, TS ? 4 : 3, TS ? 2 : 1,
                    !TS, 1'b0, TS, 1'b0, 32'h1234_5678, TS ? 32'h1 : 32'h0};
        vecs[2] = '{1'b0, 32'h1234_5679, 32'hCAFE_F00D, 3, 1'b1, TS ? 10 : 6, TS ? 8 : 4,
                    1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5679, TS ? 32'hCAFE_F00D : 32'h0};
        vecs[3] = '{1'b0, 32'h1234_5678, 32'hCAFE_F00D, 3, 1'b1, TS ? 10 : 6, TS ? 8 : 4,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, TS ? 32'hCAFE_F00D : 32'h0};
        vecs[4] = '{1'b0, 32'h0, 32'h0, 1, 1'b1, TS ? 6 : 4, TS ? 4 : 2,
                    1'b0, 1'b1, TS, 1'b0, 32'h0, 32'h0};
        vecs[5] = '{1'b1, 32'hDEAD_BEEF, 32'h0, 0, 1'b1, TS ? 4 : 3, TS ? 2 : 1,
                    1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0};
        vecs[6] = '{1'b1, 32'h0, 32'h0, 3, 1'b1, TS ? 10 : 6, TS ? 8 : 4,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[7] = '{1'b1, 32'h0, 32'h0, 1000, 1'b0, 5, 4,
                    1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};

        reset_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; sel_b = 1'b0;
        id_a = '0; ts_a = '0; stall_a = 0;
        id_b = '0; ts_b = '0; stall_b = 0;
        repeat (3) @(negedge clk);
        chk("rst_outs_a", {25'd0, addr_a, read_a, busy_a, done_a, pass_a, idmm_a, tsmm_a, to_a} , 32'd0);
        chk("rst_outs_b", {25'd0, addr_b, read_b, busy_b, done_b, pass_b, idmm_b, tsmm_b, to_b} , 32'd0);
        chk("rst_vals_a", idv_a | tsv_a, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {30'd0, busy_a, read_a}, 32'd0);

        // Table-driven sequences
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].b) begin
                id_b = vecs[i].id; ts_b = vecs[i].ts; stall_b = vecs[i].stalls;
            end else begin
                id_a = vecs[i].id; ts_a = vecs[i].ts; stall_a = vecs[i].stalls;
            end
            run_seq(vecs[i].b, vecs[i].hold, dc, rd);
            chk($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_dc);
            chk($sformatf("v%0d_read_cycles", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_pass", i), {31'd0, m_pass}, {31'd0, vecs[i].exp_pass});
            chk($sformatf("v%0d_id_mm", i), {31'd0, m_idmm}, {31'd0, vecs[i].exp_idmm});
            chk($sformatf("v%0d_ts_mm", i), {31'd0, m_tsmm}, {31'd0, vecs[i].exp_tsmm});
            chk($sformatf("v%0d_timeout", i), {31'd0, m_to}, {31'd0, vecs[i].exp_to});
            chk($sformatf("v%0d_id_value", i), m_idv, vecs[i].exp_idv);
            chk($sformatf("v%0d_ts_value", i), m_tsv, vecs[i].exp_tsv);
            chk($sformatf("v%0d_read_idle", i), {31'd0, m_read}, 32'd0);
        end

        // Back-to-back checks with start held high
        sel_b = 1'b0;
        id_a = 32'h1234_5678; ts_a = 32'hCAFE_F00D; stall_a = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        n = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            if (done_a) n++;
        end
        start_a = 1'b0;
        chk("b2b_done_count", n, TS ? 4 : 5);
        repeat (8) @(negedge clk);
        chk("b2b_settle_busy", {31'd0, busy_a}, 32'd0);
        chk("b2b_pass", {31'd0, pass_a}, 32'd1);

        // Reset during a stalled read (timestamp read when present)
        stall_a = 3;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        found = 1'b0;
        for (int cyc = 1; cyc <= 20 && !found; cyc++) begin
            @(negedge clk);
            if (read_a && (addr_a == TS)) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL rst_wait: target read state not reached");
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_read", {31'd0, read_a}, 32'd0);
        chk("rst_mid_flags", {26'd0, addr_a, busy_a, done_a, pass_a, idmm_a, tsmm_a}, 32'd0);
        chk("rst_mid_values", idv_a | tsv_a, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (busy_a || read_a || done_a) n++;
        end
        chk("rst_stays_idle", n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
